// File: rtl/mm_accel_pkg.sv
// ============================================================================
// Module      : mm_accel_pkg
// Description : Shared types and default constants for the word serializer.
//               Holds the serializer state enum and the default word width
//               and vector depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_accel_pkg;

    // Default number of bits per word
    localparam int DEFAULT_WIDTH = 32;
    // Default number of words per input vector
    localparam int DEFAULT_DEPTH = 32;

    // IDLE: waiting for a vector; SEND: emitting captured words
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : mm_accel_pkg

`default_nettype wire

// File: rtl/word_mux.sv
// ============================================================================
// Module      : word_mux
// Description : Purely combinational word selector. Picks word i_sel out of a
//               packed vector in which word k occupies
//               bits [(k+1)*WIDTH-1 : k*WIDTH].
// Ports       : i_sel  - index of the word to select
//               i_data - packed DEPTH*WIDTH input vector
//               o_word - selected WIDTH-bit word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_mux #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic [$clog2(DEPTH)-1:0] i_sel,
    input  logic [DEPTH*WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]         o_word
);

    // Unpack the flat vector so the select is a plain array index
    logic [WIDTH-1:0] w_words [DEPTH];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_unpack
            assign w_words[k] = i_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign o_word = w_words[i_sel];

endmodule : word_mux

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module      : word_serializer
// Description : Accepts a packed vector of DEPTH words and emits the first
//               in_count words (0 means DEPTH) one per handshake on a
//               valid/ready output stream. One idle bubble separates vectors.
// Config      : define WORD_SERIALIZER_REVERSE_EN for descending emission
//               order (index count-1 down to 0); default is ascending.
// Ports       : clk       - clock, all state updates on rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - upstream offers a vector
//               in_ready  - block can accept a vector (IDLE)
//               in_data   - packed DEPTH*WIDTH vector
//               in_count  - number of words to emit, 0 means DEPTH
//               out_valid - out_data holds a word
//               out_ready - downstream accepts the word
//               out_data  - current word (0 outside SEND)
//               out_idx   - index of current word (0 outside SEND)
//               out_last  - current word is the final one of the vector
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer
    import mm_accel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DEPTH*WIDTH-1:0]   in_data,
    input  logic [$clog2(DEPTH)-1:0] in_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     out_last
);

    localparam int SEL_W = $clog2(DEPTH);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DEPTH*WIDTH-1:0] r_data;
    logic [SEL_W-1:0]       r_idx;

    logic [SEL_W-1:0]       w_start;
    logic [SEL_W-1:0]       w_end;
    logic [SEL_W-1:0]       w_next;
    logic                   w_at_end;
    logic [WIDTH-1:0]       w_word;

`ifdef WORD_SERIALIZER_REVERSE_EN
    // Descending: start at count-1 (count 0 wraps to DEPTH-1), finish at 0
    assign w_start = in_count - SEL_W'(1);
    assign w_end   = '0;
    assign w_next  = r_idx - SEL_W'(1);
`else
    // Ascending: start at 0, finish at count-1 (count 0 wraps to DEPTH-1)
    logic [SEL_W-1:0] r_cnt;

    assign w_start = '0;
    assign w_end   = r_cnt - SEL_W'(1);
    assign w_next  = r_idx + SEL_W'(1);
`endif

    assign w_at_end = (r_idx == w_end);

    word_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_mux (
        .i_sel  (r_idx),
        .i_data (r_data),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_idx       <= '0;
`ifndef WORD_SERIALIZER_REVERSE_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data      <= in_data;
                        r_idx       <= w_start;
`ifndef WORD_SERIALIZER_REVERSE_EN
                        r_cnt       <= in_count;
`endif
                        r_state     <= SEND;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (w_at_end) begin
                            // Index parks at 0 so out_idx reads 0 in IDLE
                            r_state     <= IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_idx       <= '0;
                        end else begin
                            r_idx <= w_next;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_idx;
    assign out_data  = (r_state == SEND) ? w_word : '0;
    assign out_last  = (r_state == SEND) && w_at_end;

endmodule : word_serializer

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// Module      : tb_word_serializer
// Description : Self-checking bench for word_serializer. Vectors of random or
//               patterned words are offered; the expected emission order is
//               derived from the word count and order rule, and every output
//               is compared each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_serializer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int SEL_W = $clog2(DEPTH);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [DEPTH*WIDTH-1:0] in_data = '0;
    logic [SEL_W-1:0]       in_count = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_idx;
    logic                   out_last;

    int checks = 0;
    int errors = 0;

    word_serializer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Position j of an n-word vector maps to this word index
    function automatic int order_idx(input int j, input int n);
`ifdef WORD_SERIALIZER_REVERSE_EN
        return n - 1 - j;
`else
        return j;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_data"},  64'(out_data),  64'd0);
        chk({tag, "_out_idx"},   64'(out_idx),   64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
    endtask

    // Offer one vector and follow it through to the bubble.
    //   cnt        : in_count field (0 means DEPTH)
    //   pattern    : 1 -> word k = 0xA000_0000+k, else random words
    //   stall_j    : output position where out_ready is held low stall_len cycles
    //   rnd_ready  : randomise out_ready elsewhere
    //   junk       : keep in_valid high with other data during SEND
    //   hold_end   : leave in_valid high after the last transfer
    //   abort_after: return after this many transfers (0 = run to completion)
    task automatic send_vector(input int cnt, input bit pattern, input int stall_j,
                               input int stall_len, input bit rnd_ready, input bit junk,
                               input bit hold_end, input int abort_after);
        logic [WIDTH-1:0]       w [DEPTH];
        logic [DEPTH*WIDTH-1:0] pk;
        int                     n;
        int                     e;
        int                     k;
        bit                     rdy;

        n = (cnt == 0) ? DEPTH : cnt;
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = pattern ? (32'hA000_0000 + 32'(i)) : 32'($urandom);
            pk[i*WIDTH +: WIDTH] = w[i];
        end

        chk("pre_in_ready",  64'(in_ready),  64'd1);
        chk("pre_out_valid", 64'(out_valid), 64'd0);
        in_valid  = 1'b1;
        in_data   = pk;
        in_count  = SEL_W'(cnt);
        out_ready = 1'b0;
        step();

        in_valid = junk;
        if (junk) begin
            in_data  = ~pk;
            in_count = SEL_W'(cnt + 1);
        end

        for (int j = 0; j < n; j++) begin
            e   = order_idx(j, n);
            k   = 0;
            rdy = 1'b0;
            while (!rdy) begin
                chk("out_valid", 64'(out_valid), 64'd1);
                chk("in_ready",  64'(in_ready),  64'd0);
                chk("out_idx",   64'(out_idx),   64'(e));
                chk("out_data",  64'(out_data),  64'(w[e]));
                chk("out_last",  64'(out_last),  64'(j == n - 1));
                if (j == stall_j && k < stall_len) rdy = 1'b0;
                else if (rnd_ready)                rdy = ($urandom_range(0, 2) != 0);
                else                               rdy = 1'b1;
                out_ready = rdy;
                if (rdy && j == n - 1) in_valid = hold_end;
                step();
                k++;
            end
            if (abort_after > 0 && j + 1 == abort_after) begin
                out_ready = 1'b0;
                return;
            end
        end
        out_ready = 1'b0;
        chk_idle("bubble");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Full-depth patterned vector, downstream always ready
        send_vector(0, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Three words with a four-cycle stall on the second output
        send_vector(3, 1'b0, 1, 4, 1'b0, 1'b0, 1'b0, 0);

        // Single word with junk offered during SEND
        send_vector(1, 1'b0, -1, 0, 1'b0, 1'b1, 1'b0, 0);

        // Reset after 5 of 32 words
        send_vector(0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        step();
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_data",  64'(out_data),  64'd0);
        chk("rst_mid_out_idx",   64'(out_idx),   64'd0);
        rst_n = 1'b1;
        step();
        chk_idle("rst_release");
        send_vector(4, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Four-word vector
        send_vector(4, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back vectors with in_valid held high across the bubble
        for (int v = 0; v < 6; v++) begin
            send_vector($urandom_range(0, DEPTH - 1), 1'b0, -1, 0, 1'b1, 1'b0, (v < 5), 0);
        end

        // Randomised counts, backpressure and junk offers
        for (int v = 0; v < 10; v++) begin
            send_vector($urandom_range(0, DEPTH - 1), 1'b0, $urandom_range(0, 3),
                        $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_word_serializer

`default_nettype wire

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 32, bits per word.
REQ-002 Parameter DEPTH, default 32, words per input vector; power of two, 2..256.
REQ-003 Localparam SEL_W = $clog2(DEPTH), index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream offers a vector.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 in_data  input  DEPTH*WIDTH  packed vector; word k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-009 in_count  input  SEL_W  words to emit; 0 means DEPTH.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  WIDTH  current word.
REQ-013 out_idx  output  SEL_W  index of current word within vector.
REQ-014 out_last  output  1  current word is the final one of the vector.

Function
REQ-015 Two states: IDLE, SEND.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid, the block SHALL capture in_data and in_count into internal registers, set the index to its start value, and go to SEND.
REQ-017 SEND: in_ready=0, out_valid=1; in_valid/in_data ignored.
REQ-018 out_data SHALL equal the captured word at out_idx, a combinational select from registers; first word valid on the cycle after acceptance.
REQ-019 Transfer occurs when out_valid && out_ready; the index SHALL advance by one per transfer, else hold.
REQ-020 out_data, out_idx, out_last SHALL be stable while out_valid && !out_ready.
REQ-021 out_last=1 on the word with the final emitted index (the count-th word).
REQ-022 Transfer with out_last=1 SHALL return to IDLE; in_ready rises on the next cycle (one bubble per vector; N words take N+1 cycles minimum).
REQ-023 in_count=1: single word, out_last=1 on it; in_count=0: DEPTH words.
REQ-024 Index arithmetic is SEL_W bits; the block SHALL never emit beyond count words, so no wrap is observable.
REQ-025 Outside SEND, out_data, out_idx, out_last SHALL be 0.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, index 0, buffer 0; in_ready=1 on the first cycle after reset release; out_valid=0, out_data=0, out_idx=0, out_last=0.
REQ-027 Reset mid-vector SHALL discard the remaining words with no further out_valid.

Configuration
REQ-028 Macro WORD_SERIALIZER_REVERSE_EN defined: emission order descending, index starts at count-1 and ends at 0 (out_last at out_idx=0).
REQ-029 Macro undefined: ascending order, index starts at 0 and ends at count-1; no reverse logic present.

Structure
REQ-030 Package mm_accel_pkg SHALL hold the state enum type (IDLE, SEND) and default WIDTH/DEPTH constants.
REQ-031 Sub-module word_mux (parameters WIDTH, DEPTH; sel, packed data in, word out, purely combinational) SHALL implement the REQ-018 select.

Verification
REQ-032 WIDTH=32, DEPTH=32, word k=0xA000_0000+k, in_count=0, out_ready=1 -> 32 words 0xA0000000..0xA000001F on consecutive cycles, out_idx 0..31, out_last only on idx 31, in_ready high next cycle.
REQ-033 in_count=3, out_ready low on cycle of idx 1 for 4 cycles -> idx 1 word held stable 5 cycles, then idx 2 with out_last=1; 3 transfers total.
REQ-034 in_count=1 -> exactly one word (idx 0, out_last=1); in_valid asserted during SEND with different data -> not captured, in_ready=0.
REQ-035 rst_n low after 5 of 32 words -> next cycle out_valid=0, in_ready=1 after release, new vector starts at idx 0.
REQ-036 WORD_SERIALIZER_REVERSE_EN defined, in_count=4 -> out_idx 3,2,1,0 with matching words, out_last at idx 0.
REQ-037 DEPTH=4, WIDTH=8, back-to-back vectors with in_valid held high -> one idle bubble between vectors, no word lost or duplicated.
